nios_system_keys_in: RTL

Avalon-MM slave input port that samples an external parallel input bus (pushbuttons/switches) for the Nios II system. It is the input-direction companion of the HEX display output ports. Each input bit passes through a synchronizer, optional debounce and an edge detector. The block holds a per-bit edge-capture register and an interrupt mask, and raises a level-sensitive `irq` to the processor.

---
 rtl/nios_system_pio_pkg.sv | 13 +
 rtl/nios_system_pio_debounce.sv | 89 ++++++++
 rtl/nios_system_keys_in.sv | 102 ++++++++++
 3 files changed

// File: rtl/nios_system_pio_pkg.sv
// Shared constants for the Nios II parallel-input (keys/switches) port:
// Avalon word addresses and edge-capture modes.
package nios_system_pio_pkg;

  localparam logic [1:0] PIO_ADDR_DATA = 2'd0;
  localparam logic [1:0] PIO_ADDR_MASK = 2'd2;
  localparam logic [1:0] PIO_ADDR_EDGE = 2'd3;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/nios_system_pio_debounce.sv
// Input conditioning for the keys port: 2-flop synchronizer and, when
// KEYS_IN_DEBOUNCE_EN is defined, a shared stability counter in front of in_val.
module nios_system_pio_debounce
  import nios_system_pio_pkg::*;
#(
  parameter int   WIDTH           = 4,
  parameter logic IDLE_LEVEL      = 1'b1,
  parameter int   DEBOUNCE_CYCLES = 50000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] in_val,
  output logic [WIDTH-1:0] in_val_next
);

  logic [WIDTH-1:0] sync1_r;
  logic [WIDTH-1:0] sync2_r;
  logic [WIDTH-1:0] in_val_r;
  logic [WIDTH-1:0] in_val_next_s;
  logic             unused_cfg_s;

  assign unused_cfg_s = (DEBOUNCE_CYCLES > 0);

  // Two-flop synchronizer, preset to the idle level so reset creates no edge
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_r <= {WIDTH{IDLE_LEVEL}};
      sync2_r <= {WIDTH{IDLE_LEVEL}};
    end else begin
      sync1_r <= in_port;
      sync2_r <= sync1_r;
    end
  end

`ifdef KEYS_IN_DEBOUNCE_EN
  localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] cnt_r;
  logic             changing_s;

  // sync1 != sync2 means sync2 takes a new value on this edge; restarting the
  // count here makes in_val move exactly DEBOUNCE_CYCLES edges after sync2 does
  assign changing_s = (sync1_r != sync2_r);

  // Shared stability counter, saturating at DEBOUNCE_CYCLES
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (changing_s) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (cnt_r != CNT_MAX) begin
      cnt_r <= cnt_r + 1'b1;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Accept sync2 once it has been stable long enough
  always_comb begin
    in_val_next_s = in_val_r;
    if (!changing_s && (cnt_r == CNT_LOAD)) begin
      in_val_next_s = sync2_r;
    end else begin
      in_val_next_s = in_val_r;
    end
  end
`else
  // Without filtering in_val simply follows sync2 one cycle later
  always_comb begin
    in_val_next_s = sync2_r;
  end
`endif

  // Filtered input register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      in_val_r <= {WIDTH{IDLE_LEVEL}};
    end else begin
      in_val_r <= in_val_next_s;
    end
  end

  assign in_val      = in_val_r;
  assign in_val_next = in_val_next_s;

endmodule

// File: rtl/nios_system_keys_in.sv
// Avalon-MM keys/switches input port with edge capture and level irq.
// Optional input debounce is enabled by defining KEYS_IN_DEBOUNCE_EN.
module nios_system_keys_in
  import nios_system_pio_pkg::*;
#(
  parameter int   WIDTH           = 4,
  parameter int   EDGE_MODE       = 1,
  parameter logic IDLE_LEVEL      = 1'b1,
  parameter int   DEBOUNCE_CYCLES = 50000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  logic [WIDTH-1:0] in_val_s;
  logic [WIDTH-1:0] in_val_next_s;
  logic [WIDTH-1:0] edge_s;
  logic [WIDTH-1:0] cap_clr_s;
  logic [WIDTH-1:0] mask_r;
  logic [WIDTH-1:0] cap_r;
  logic             irq_r;
  logic             wr_s;
  logic             unused_wdata_s;

  nios_system_pio_debounce #(
    .WIDTH           (WIDTH),
    .IDLE_LEVEL      (IDLE_LEVEL),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk         (clk),
    .reset_n     (reset_n),
    .in_port     (in_port),
    .in_val      (in_val_s),
    .in_val_next (in_val_next_s)
  );

  assign wr_s           = chipselect && !write_n;
  assign unused_wdata_s = &{1'b0, writedata};
  assign cap_clr_s      = (wr_s && (address == PIO_ADDR_EDGE)) ? writedata[WIDTH-1:0]
                                                               : {WIDTH{1'b0}};

  // Edge detect against the value about to load, so capture lands with in_val
  always_comb begin
    edge_s = {WIDTH{1'b0}};
    case (EDGE_MODE)
      EDGE_RISE: edge_s = in_val_next_s & ~in_val_s;
      EDGE_FALL: edge_s = ~in_val_next_s & in_val_s;
      EDGE_ANY:  edge_s = in_val_next_s ^ in_val_s;
      default:   edge_s = {WIDTH{1'b0}};
    endcase
  end

  // Interrupt mask register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mask_r <= {WIDTH{1'b0}};
    end else if (wr_s && (address == PIO_ADDR_MASK)) begin
      mask_r <= writedata[WIDTH-1:0];
    end else begin
      mask_r <= mask_r;
    end
  end

  // Edge capture, write-1-to-clear; a new edge outranks a same-cycle clear
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cap_r <= {WIDTH{1'b0}};
    end else begin
      cap_r <= (cap_r & ~cap_clr_s) | edge_s;
    end
  end

  // Registered level interrupt
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_r <= 1'b0;
    end else begin
      irq_r <= |(cap_r & mask_r);
    end
  end

  assign irq = irq_r;

  // Zero-wait-state read mux
  always_comb begin
    readdata = 32'd0;
    case (address)
      PIO_ADDR_DATA: readdata[WIDTH-1:0] = in_val_s;
      PIO_ADDR_MASK: readdata[WIDTH-1:0] = mask_r;
      PIO_ADDR_EDGE: readdata[WIDTH-1:0] = cap_r;
      default:       readdata = 32'd0;
    endcase
  end

endmodule
